// File: rtl/y86_pkg.sv
// Shared Y86-64 constants and the W pipeline register layout used by the memory stage.
package y86_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SHLT = 3'd2;
   localparam logic [2:0] SADR = 3'd3;
   localparam logic [2:0] SINS = 3'd4;

   localparam logic [3:0] RNONE = 4'hF;

   typedef struct packed {
      logic [2:0]  stat;
      logic [3:0]  icode;
      logic [3:0]  dst_e;
      logic [3:0]  dst_m;
      logic [63:0] val_e;
      logic [63:0] val_m;
   } w_reg_t;

   localparam w_reg_t WBubble = '{
      stat:  SAOK,
      icode: INOP,
      dst_e: RNONE,
      dst_m: RNONE,
      val_e: 64'd0,
      val_m: 64'd0
   };

endpackage

// File: rtl/mem_pipe_if.sv
// M-stage inputs, pipeline controls and W-stage / forwarding outputs of the memory stage.
interface mem_pipe_if;

   logic [2:0]  M_stat;
   logic [3:0]  M_in_code;
   logic [63:0] M_val_e;
   logic [63:0] M_val_a;
   logic [3:0]  M_dst_e;
   logic [3:0]  M_dst_m;
   logic        W_stall;
   logic        W_bubble;

   logic [2:0]  W_stat;
   logic [3:0]  W_in_code;
   logic [3:0]  W_dst_e;
   logic [3:0]  W_dst_m;
   logic [63:0] W_val_e;
   logic [63:0] W_val_m;
   logic [63:0] m_val_m;
   logic [2:0]  m_stat;

   modport master (
      output M_stat, M_in_code, M_val_e, M_val_a, M_dst_e, M_dst_m, W_stall, W_bubble,
      input  W_stat, W_in_code, W_dst_e, W_dst_m, W_val_e, W_val_m, m_val_m, m_stat
   );

   modport slave (
      input  M_stat, M_in_code, M_val_e, M_val_a, M_dst_e, M_dst_m, W_stall, W_bubble,
      output W_stat, W_in_code, W_dst_e, W_dst_m, W_val_e, W_val_m, m_val_m, m_stat
   );

endinterface

// File: rtl/data_mem.sv
// Byte-addressed data memory: one 8-byte little-endian combinational read port,
// one 8-byte write port committed on the clock, unaligned access, bounds check.
module data_mem #(
   parameter int unsigned MEM_BYTES = 1024
) (
   input  logic        clock,
   input  logic [63:0] addr_i,
   input  logic        en_i,
   input  logic        we_i,
   input  logic [63:0] wdata_i,
   output logic [63:0] rdata_o,
   output logic        error_o
);

   localparam int unsigned AW      = $clog2(MEM_BYTES);
   localparam logic [63:0] MaxAddr = 64'(MEM_BYTES - 8);

   logic [7:0]    mem_q [MEM_BYTES];
   logic [AW-1:0] base;

   // Full-width compare so huge addresses never wrap into range.
   assign error_o = en_i && (addr_i > MaxAddr);
   assign base    = addr_i[AW-1:0];

   always_comb begin
      rdata_o = '0;
      if (!error_o) begin
         for (int i = 0; i < 8; i++) begin
            rdata_o[8*i +: 8] = mem_q[base + AW'(i)];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (we_i && !error_o) begin
         for (int i = 0; i < 8; i++) begin
            mem_q[base + AW'(i)] <= wdata_i[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/mem_pipe.sv
// Y86-64 memory stage: address/control decode, data memory access and the W pipeline register.
module mem_pipe
   import y86_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 1024
) (
   input logic     clock,
   input logic     reset,
   mem_pipe_if.slave bus
);

   logic [63:0] mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic        mem_we;
   logic [63:0] mem_rdata;
   logic        dmem_error;
   w_reg_t      w_d, w_q;

   always_comb begin
      mem_addr = '0;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      case (bus.M_in_code)
         IRMMOVQ, ICALL, IPUSHQ: begin
            mem_addr = bus.M_val_e;
            mem_wr   = 1'b1;
         end
         IMRMOVQ: begin
            mem_addr = bus.M_val_e;
            mem_rd   = 1'b1;
         end
         IRET, IPOPQ: begin
            mem_addr = bus.M_val_a;
            mem_rd   = 1'b1;
         end
         default: ;
      endcase
   end

   // A faulted or stalled instruction, or a reset cycle, must leave memory untouched.
   assign mem_we = mem_wr && (bus.M_stat == SAOK) && !dmem_error && !bus.W_stall && !reset;

   data_mem #(
      .MEM_BYTES(MEM_BYTES)
   ) u_data_mem (
      .clock  (clock),
      .addr_i (mem_addr),
      .en_i   (mem_rd | mem_wr),
      .we_i   (mem_we),
      .wdata_i(bus.M_val_a),
      .rdata_o(mem_rdata),
      .error_o(dmem_error)
   );

   assign bus.m_stat  = dmem_error ? SADR : bus.M_stat;
   assign bus.m_val_m = (mem_rd && !dmem_error) ? mem_rdata : 64'd0;

   always_comb begin
      w_d = w_q;
      if (bus.W_stall) begin
         w_d = w_q;
      end else if (bus.W_bubble) begin
         w_d = WBubble;
      end else begin
         w_d.stat  = bus.m_stat;
         w_d.icode = bus.M_in_code;
         w_d.dst_e = bus.M_dst_e;
         w_d.dst_m = bus.M_dst_m;
         w_d.val_e = bus.M_val_e;
         w_d.val_m = bus.m_val_m;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         w_q <= WBubble;
      end else begin
         w_q <= w_d;
      end
   end

   assign bus.W_stat    = w_q.stat;
   assign bus.W_in_code = w_q.icode;
   assign bus.W_dst_e   = w_q.dst_e;
   assign bus.W_dst_m   = w_q.dst_m;
   assign bus.W_val_e   = w_q.val_e;
   assign bus.W_val_m   = w_q.val_m;

endmodule

// File: doc/mem_pipe.md
MEM_PIPE -- requirements
Module: mem_pipe

Interface
REQ-001 The block SHALL have parameter MEM_BYTES, default 1024: data memory size in bytes.
REQ-002 Port clock SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port reset SHALL be an input, 1 bit: synchronous reset, active-high.
REQ-004 Port M_stat SHALL be an input, 3 bits: status of the M-stage instruction (AOK=1, HLT=2, ADR=3, INS=4).
REQ-005 Port M_in_code SHALL be an input, 4 bits: M-stage icode.
REQ-006 Port M_val_e SHALL be an input, 64 bits: ALU result or memory address.
REQ-007 Port M_val_a SHALL be an input, 64 bits: store data or pop/ret address.
REQ-008 Ports M_dst_e and M_dst_m SHALL be inputs, 4 bits each: destination register IDs, with F = none.
REQ-009 Ports W_stall and W_bubble SHALL be inputs, 1 bit each: W-register hold and inject-nop controls from pipeline control.
REQ-010 Ports W_stat (3 bits), W_in_code (4), W_dst_e (4), W_dst_m (4), W_val_e (64) and W_val_m (64) SHALL be registered outputs feeding writeback.
REQ-011 Ports m_val_m (64 bits) and m_stat (3 bits) SHALL be combinational outputs for decode forwarding and pipeline control.

Function
REQ-012 Address selection SHALL be: M_val_e for icodes 4, 5, 8 and A; M_val_a for icodes 9 and B; otherwise no access.
REQ-013 Read icodes SHALL be 5, 9 and B; write icodes SHALL be 4, 8 and A.
REQ-014 Write data SHALL be M_val_a for all write icodes.
REQ-015 Memory SHALL be a byte array; each access SHALL cover 8 bytes, little-endian, at byte address addr..addr+7, with no alignment requirement.
REQ-016 An access SHALL be invalid (dmem_error) when addr > MEM_BYTES-8, using a full 64-bit unsigned compare with no wrap-around.
REQ-017 m_stat SHALL be ADR when dmem_error is set, else M_stat.
REQ-018 m_val_m SHALL be the combinational 8-byte read for a valid read icode, else 0.
REQ-019 A memory write SHALL commit at the rising edge only if: write icode, M_stat==AOK, no dmem_error, W_stall==0, reset==0.
REQ-020 A read in the same cycle as a write to overlapping bytes SHALL return the pre-write contents; the new data SHALL be visible from the next cycle.
REQ-021 W register update priority: reset > W_stall (hold all W_*) > W_bubble (load nop) > normal load.
REQ-022 A normal load SHALL capture W_stat=m_stat, W_in_code=M_in_code, W_dst_e=M_dst_e, W_dst_m=M_dst_m, W_val_e=M_val_e, W_val_m=m_val_m.
REQ-023 The nop/bubble value SHALL be W_stat=AOK, W_in_code=1, W_dst_e=F, W_dst_m=F, W_val_e=0, W_val_m=0.
REQ-024 When W_stall and W_bubble are asserted together, W_stall SHALL win and the bubble SHALL be ignored.
REQ-025 Latency SHALL be one cycle from M inputs to W outputs; m_val_m and m_stat SHALL have zero latency.
REQ-026 An instruction entering with M_stat != AOK SHALL pass its stat unchanged and SHALL NOT write memory.

Reset
REQ-027 While reset is high at a rising edge, all W_* outputs SHALL load the bubble value of REQ-023.
REQ-028 Reset SHALL NOT alter memory contents, and no memory write SHALL occur during a cycle with reset high.
REQ-029 Reset asserted mid-stall SHALL override the stall.

Structure
REQ-030 Package y86_pkg SHALL hold the icode constants, stat codes (AOK/HLT/ADR/INS) and RNONE=4'hF; mem_pipe and wb_pipe SHALL share it.
REQ-031 The memory array with one 8-byte read port, one 8-byte write port and the bounds check SHALL be sub-module data_mem.
REQ-032 mem_pipe SHALL contain the address/control decode and the W pipeline register.

Verification
REQ-033 Store then load: rmmovq (icode 4), M_val_e=0x40, M_val_a=0x1122334455667788; next cycle mrmovq (icode 5), M_val_e=0x40 -> W_val_m=0x1122334455667788 one cycle later, W_stat=AOK.
REQ-034 Bounds check with MEM_BYTES=1024: mrmovq at 0x3F8 -> AOK; mrmovq at 0x3F9 -> m_stat=ADR, W_stat=ADR; rmmovq at 0xFFFFFFFFFFFFFFFC -> ADR and no memory change.
REQ-035 Stall/bubble: with W loaded, W_stall=1 for 2 cycles -> W_* held and a concurrent pushq does not write; then W_bubble=1 -> W_in_code=1, W_dst_e=F, W_dst_m=F; W_stall and W_bubble together -> hold.
REQ-036 popq (icode B), M_val_a=0x100 (containing 0xAB), M_val_e=0x108, M_dst_e=4, M_dst_m=3 -> W_val_e=0x108, W_val_m=0xAB, W_dst_e=4, W_dst_m=3.
REQ-037 Reset mid-operation: assert reset during a rmmovq cycle -> memory unchanged, W_* equal the bubble values, and previously written data is still readable afterwards.
REQ-038 Faulted input: M_stat=INS with icode 4 -> no write, W_stat=INS.
